iob_wb2iob: RTL
===============

# iob_wb2iob

Wishbone-classic slave to IOb-bus initiator bridge, the reverse of the IOb-to-Wishbone adapter in front of the UART16550 core. It lets a Wishbone master, such as a debug or DMA port, access any IOb-native peripheral, including `iob_uart16550`. Each Wishbone cycle becomes one IOb request. The bridge holds `avalid` until `ready`, waits for `rvalid` on reads, and returns `ack` (or `err`) to the master.

## Interface
- `ADDR_W`, 32, address width on both sides
- `DATA_W`, 32, data width; must be a multiple of 8
- `TIMEOUT_W`, 8, timeout counter width; used only with `IOB_WB2IOB_TIMEOUT_EN`

- `clk_i`  in  1  clock
- `arst_n_i`  in  1  reset; one clock; reset is asynchronous and active-low
- `wb_cyc_i`  in  1  Wishbone cycle
- `wb_stb_i`  in  1  Wishbone strobe
- `wb_we_i`  in  1  write enable
- `wb_adr_i`  in  ADDR_W  address
- `wb_dat_i`  in  DATA_W  write data
- `wb_sel_i`  in  DATA_W/8  byte selects
- `wb_dat_o`  out  DATA_W  read data, valid while `wb_ack_o`=1
- `wb_ack_o`  out  1  transfer done, one-cycle pulse
- `wb_err_o`  out  1  transfer failed, one-cycle pulse; tied 0 without the macro
- `iob_avalid_o`  out  1  IOb request valid
- `iob_addr_o`  out  ADDR_W  IOb address
- `iob_wdata_o`  out  DATA_W  IOb write data
- `iob_wstrb_o`  out  DATA_W/8  IOb write strobes; 0 means read
- `iob_ready_i`  in  1  IOb request accepted
- `iob_rvalid_i`  in  1  IOb read data valid
- `iob_rdata_i`  in  DATA_W  IOb read data

## Operation
- All outputs are registered. Reset value of every output is 0. State resets to IDLE.
- **IDLE**
  - When `wb_cyc_i & wb_stb_i` is sampled, latch `adr`, `dat`, `sel` and `we`; clear the abort flag; go to REQ.
  - `iob_rvalid_i` arriving in IDLE is discarded.
- **REQ**
  - Drive `iob_avalid_o`=1, `iob_addr_o`=latched address, `iob_wdata_o`=latched data.
  - Drive `iob_wstrb_o` = `we ? sel : 0`.
  - A write with `sel`=0 is forced to `wstrb`=all-ones so it is never mistaken for a read.
  - On `iob_ready_i`:
    - write: go to ACK;
    - read with `iob_rvalid_i` in the same cycle: capture `iob_rdata_i`, go to ACK;
    - read otherwise: go to WAIT_R.
  - `avalid`, `addr`, `wdata` and `wstrb` stay constant until `ready` is seen.
- **WAIT_R**
  - `iob_avalid_o`=0.
  - On `iob_rvalid_i`: capture `iob_rdata_i` into `wb_dat_o`, go to ACK.
- **ACK**
  - Pulse `wb_ack_o` for exactly one cycle unless the abort flag is set; then go to IDLE.
  - `wb_dat_o` keeps the last read data. Writes do not change it.
- **Abort**
  - If `wb_cyc_i` drops while in REQ or WAIT_R, set the abort flag.
  - The IOb transaction still runs to completion, because an IOb request is never retracted.
  - No `ack` or `err` is issued for an aborted cycle.
- Only one outstanding IOb transaction at a time. A new Wishbone cycle is only sampled in IDLE.

## Timing
- Zero-wait peripheral (`ready`=1, `rvalid` one cycle after `ready`):
  - read `ack` arrives 3 cycles after the `stb` sample edge;
  - write `ack` arrives 2 cycles after it.
- Back-to-back transfers: IDLE samples again the cycle after ACK. Minimum 3 cycles per write, 4 per read.
- Reset asserted mid-transaction: outputs drop to 0 at once with no completion. A late `rvalid` after reset is ignored.

## Configuration
- `IOB_WB2IOB_TIMEOUT_EN` defined:
  - A TIMEOUT_W-bit counter clears on entry to REQ or WAIT_R and increments each cycle spent there.
  - At 2^TIMEOUT_W−1 cycles, go to ERR: drop `iob_avalid_o`, pulse `wb_err_o` for one cycle with `wb_dat_o`=0, then return to IDLE.
  - Abort suppresses `err` the same way it suppresses `ack`.
  - A stale `rvalid` after a timeout is discarded in IDLE.
- Undefined: no counter; REQ and WAIT_R wait indefinitely; `wb_err_o`=0.

## Structure
- Package `iob_wb2iob_pkg` holds:
  - state encoding localparams (IDLE, REQ, WAIT_R, ACK, ERR; 3 bits);
  - default `ADDR_W`, `DATA_W`, `TIMEOUT_W`.
- Sub-module `iob_wb2iob_timeout`: counter with clear and enable inputs and an `expired_o` output. It is instantiated only under `IOB_WB2IOB_TIMEOUT_EN`.

## Test plan
- Write, `adr`=0x4, `dat`=0xA5, `sel`=4'b0001, `ready`=1 → `iob_wstrb_o`=4'b0001 for 1 cycle, `wb_ack_o` 2 cycles after the sample edge.
- Read, `adr`=0x14, `ready` held 0 for 5 cycles, then `rvalid` 2 cycles later with `rdata`=0x60 → `avalid` stable 6 cycles, `wb_dat_o`=0x60 with a single `ack`.
- Read with `ready` and `rvalid` asserted in the same cycle, `rdata`=0xDEADBEEF → WAIT_R skipped, `ack` the next cycle with 0xDEADBEEF.
- `wb_cyc_i` dropped during WAIT_R → IOb read completes, no `ack`; the next write is acked normally.
- With macro and `TIMEOUT_W`=4, `ready` stuck at 0 → `avalid` drops after 15 cycles, one-cycle `wb_err_o`, `wb_dat_o`=0; a later stray `rvalid` is ignored.
- `arst_n_i` asserted during REQ → all outputs 0 immediately; after release, a read completes normally.

Source files
------------

// File: rtl/iob_wb2iob_pkg.sv
// Shared state encoding and default widths for the Wishbone-to-IOb bridge.
// The timeout feature is selected with IOB_WB2IOB_TIMEOUT_EN.
package iob_wb2iob_pkg;

  localparam int ADDR_W_DEF    = 32;
  localparam int DATA_W_DEF    = 32;
  localparam int TIMEOUT_W_DEF = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_REQ    = 3'd1;
  localparam logic [2:0] ST_WAIT_R = 3'd2;
  localparam logic [2:0] ST_ACK    = 3'd3;
  localparam logic [2:0] ST_ERR    = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    REQ    = ST_REQ,
    WAIT_R = ST_WAIT_R,
    ACK    = ST_ACK,
    ERR    = ST_ERR
  } state_t;

endpackage

// File: rtl/iob_wb2iob_timeout.sv
// Cycle counter for the bridge wait states; expired_o fires on the (2^TIMEOUT_W-1)th enabled cycle.
// No backpressure: clr_i has priority over en_i, and the count saturates at the limit.
module iob_wb2iob_timeout #(
  parameter int TIMEOUT_W = 8
) (
  input  logic clk_i,
  input  logic arst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  // The entry cycle is count 0, so the count lags cycles spent by one.
  localparam logic [TIMEOUT_W-1:0] LIMIT = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  logic [TIMEOUT_W-1:0] cnt;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      cnt <= '0;
    end else if (clr_i) begin
      cnt <= '0;
    end else if (en_i && !expired_o) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired_o = en_i && (cnt == LIMIT);

endmodule

// File: rtl/iob_wb2iob.sv
// Wishbone-classic slave to IOb initiator: one IOb request per cycle, ack 2 (write) / 3 (read) cycles after stb on a zero-wait target.
// Holds avalid until ready, one transfer in flight; IOB_WB2IOB_TIMEOUT_EN adds a wait-state timeout reported on wb_err_o.
module iob_wb2iob
  import iob_wb2iob_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int TIMEOUT_W = TIMEOUT_W_DEF
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [ADDR_W-1:0]   wb_adr_i,
  input  logic [DATA_W-1:0]   wb_dat_i,
  input  logic [DATA_W/8-1:0] wb_sel_i,
  output logic [DATA_W-1:0]   wb_dat_o,
  output logic                wb_ack_o,
  output logic                wb_err_o,
  output logic                iob_avalid_o,
  output logic [ADDR_W-1:0]   iob_addr_o,
  output logic [DATA_W-1:0]   iob_wdata_o,
  output logic [DATA_W/8-1:0] iob_wstrb_o,
  input  logic                iob_ready_i,
  input  logic                iob_rvalid_i,
  input  logic [DATA_W-1:0]   iob_rdata_i
);

  localparam int STRB_W = DATA_W / 8;

  state_t              state, state_n;
  logic                abort, abort_n;
  logic                we, we_n;
  logic                avalid_n;
  logic [ADDR_W-1:0]   addr_n;
  logic [DATA_W-1:0]   wdata_n;
  logic [STRB_W-1:0]   wstrb_n;
  logic                ack_n;
  logic                err_n;
  logic [DATA_W-1:0]   dat_n;
  logic                cnt_clr;
  logic                cnt_en;
  logic                expired;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state        <= IDLE;
      abort        <= 1'b0;
      we           <= 1'b0;
      iob_avalid_o <= 1'b0;
      iob_addr_o   <= '0;
      iob_wdata_o  <= '0;
      iob_wstrb_o  <= '0;
      wb_ack_o     <= 1'b0;
      wb_err_o     <= 1'b0;
      wb_dat_o     <= '0;
    end else begin
      state        <= state_n;
      abort        <= abort_n;
      we           <= we_n;
      iob_avalid_o <= avalid_n;
      iob_addr_o   <= addr_n;
      iob_wdata_o  <= wdata_n;
      iob_wstrb_o  <= wstrb_n;
      wb_ack_o     <= ack_n;
      wb_err_o     <= err_n;
      wb_dat_o     <= dat_n;
    end
  end

  always_comb begin
    state_n  = state;
    abort_n  = abort;
    we_n     = we;
    avalid_n = 1'b0;
    addr_n   = iob_addr_o;
    wdata_n  = iob_wdata_o;
    wstrb_n  = '0;
    ack_n    = 1'b0;
    err_n    = 1'b0;
    dat_n    = wb_dat_o;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;

    case (state)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          addr_n   = wb_adr_i;
          wdata_n  = wb_dat_i;
          we_n     = wb_we_i;
          abort_n  = 1'b0;
          avalid_n = 1'b1;
          // An empty write strobe would read as a read on IOb.
          if (wb_we_i) wstrb_n = (wb_sel_i == '0) ? '1 : wb_sel_i;
          cnt_clr  = 1'b1;
          state_n  = REQ;
        end
      end

      REQ: begin
        avalid_n = 1'b1;
        wstrb_n  = iob_wstrb_o;
        cnt_en   = 1'b1;
        if (!wb_cyc_i) abort_n = 1'b1;
        if (iob_ready_i) begin
          avalid_n = 1'b0;
          wstrb_n  = '0;
          if (we) begin
            state_n = ACK;
          end else if (iob_rvalid_i) begin
            dat_n   = iob_rdata_i;
            state_n = ACK;
          end else begin
            cnt_clr = 1'b1;
            state_n = WAIT_R;
          end
        end else if (expired) begin
          avalid_n = 1'b0;
          wstrb_n  = '0;
          state_n  = ERR;
        end
      end

      WAIT_R: begin
        cnt_en = 1'b1;
        if (!wb_cyc_i) abort_n = 1'b1;
        if (iob_rvalid_i) begin
          dat_n   = iob_rdata_i;
          state_n = ACK;
        end else if (expired) begin
          state_n = ERR;
        end
      end

      ACK: begin
        ack_n   = !abort;
        state_n = IDLE;
      end

      ERR: begin
        err_n   = !abort;
        dat_n   = '0;
        state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

`ifdef IOB_WB2IOB_TIMEOUT_EN
  iob_wb2iob_timeout #(
    .TIMEOUT_W(TIMEOUT_W)
  ) u_timeout (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .clr_i    (cnt_clr),
    .en_i     (cnt_en),
    .expired_o(expired)
  );
`else
  // Without the timeout, REQ and WAIT_R wait forever and ERR is unreachable.
  assign expired = 1'b0;
  logic unused_cnt;
  assign unused_cnt = cnt_clr ^ cnt_en ^ (TIMEOUT_W == 0);
`endif

endmodule
